// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    // Address-mux select codes
    localparam logic [1:0] SEL_IF   = 2'b00;
    localparam logic [1:0] SEL_DM   = 2'b01;
    localparam logic [1:0] SEL_HOLD = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    localparam int unsigned CNT_W = 2;

endpackage

// File: rtl/mem_port_arbiter_mux4to1.sv
// Generic 4:1 mux used to form the memory address.
module mem_port_arbiter_mux4to1
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    input  logic [N-1:0] d,
    input  logic [1:0]   sel,
    output logic [N-1:0] y
);

    // Select one of four inputs
    always_comb begin
        y = d;
        unique case (sel)
            SEL_IF:   y = a;
            SEL_DM:   y = b;
            SEL_HOLD: y = c;
            default:  y = d;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data load/store.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        addr_sel,
    output logic              if_stall,
    output logic              dm_stall
);

    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(MEM_LAT - 1);
    localparam logic             READ_FAST = (MEM_LAT <= 1);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [1:0]          mask_q,  mask_d;   // bit0 = IF, bit1 = DM
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                if_elig, dm_elig;

    // State and hold registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            cnt_q   <= '0;
            mask_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Grant, latency sequencing, response and requester mask
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = wdata_q;
        addr_sel  = SEL_ZERO;
        if_ack    = 1'b0;
        dm_ack    = 1'b0;
        // rst gates the grant so strobes drop as soon as reset rises
        if_elig   = if_req & ~mask_q[0] & ~rst;
        dm_elig   = dm_req & ~mask_q[1] & ~rst;

        unique case (state_q)
            IDLE: begin
                mask_d = '0;
                if (dm_elig) begin
                    owner_d   = OWN_DM;
                    mem_en    = 1'b1;
                    mem_we    = dm_we;
                    mem_wdata = dm_wdata;
                    addr_sel  = SEL_DM;
                    addr_d    = dm_addr;
                    wdata_d   = dm_wdata;
                    cnt_d     = CNT_INIT;
                    state_d   = (dm_we || READ_FAST) ? RESP : BUSY;
                end else if (if_elig) begin
                    owner_d  = OWN_IF;
                    mem_en   = 1'b1;
                    addr_sel = SEL_IF;
                    addr_d   = if_addr;
                    cnt_d    = CNT_INIT;
                    state_d  = READ_FAST ? RESP : BUSY;
                end
            end
            BUSY: begin
                // Counter hits zero on the last wait cycle: respond next
                addr_sel = SEL_HOLD;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_d == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                addr_sel = SEL_HOLD;
                if_ack   = (owner_q == OWN_IF);
                dm_ack   = (owner_q == OWN_DM);
                mask_d   = (owner_q == OWN_IF) ? 2'b01 : 2'b10;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign if_rdata = mem_rdata;
    assign dm_rdata = mem_rdata;
    assign if_stall = if_req & ~if_ack;
    assign dm_stall = dm_req & ~dm_ack;

    // Memory address mux
    mem_port_arbiter_mux4to1 #(
        .N (ADDR_W)
    ) u_addr_mux (
        .a   (if_addr),
        .b   (dm_addr),
        .c   (addr_q),
        .d   (ADDR_W'(0)),
        .sel (addr_sel),
        .y   (mem_addr)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: three arbiters with MEM_LAT 1, 2 and 3.
module tb_mem_port_arbiter;

    localparam int NI = 3;
    localparam int NV = 11;
    localparam int NRAND = 1500;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req   [NI];
    logic [31:0] if_addr  [NI];
    logic        if_ack   [NI];
    logic [31:0] if_rdata [NI];
    logic        dm_req   [NI];
    logic        dm_we    [NI];
    logic [31:0] dm_addr  [NI];
    logic [31:0] dm_wdata [NI];
    logic        dm_ack   [NI];
    logic [31:0] dm_rdata [NI];
    logic        mem_en   [NI];
    logic        mem_we   [NI];
    logic [31:0] mem_addr [NI];
    logic [31:0] mem_wdata[NI];
    logic [31:0] mem_rdata[NI];
    logic [1:0]  addr_sel [NI];
    logic        if_stall [NI];
    logic        dm_stall [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory contents as a pure function of address
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h40) return 32'h00A00093;
        return {a[15:0], ~a[15:0]};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign mem_rdata[g] = mem_f(mem_addr[g]);
        mem_port_arbiter #(
            .ADDR_W  (32),
            .DATA_W  (32),
            .MEM_LAT (g + 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_ack    (if_ack[g]),
            .if_rdata  (if_rdata[g]),
            .dm_req    (dm_req[g]),
            .dm_we     (dm_we[g]),
            .dm_addr   (dm_addr[g]),
            .dm_wdata  (dm_wdata[g]),
            .dm_ack    (dm_ack[g]),
            .dm_rdata  (dm_rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .addr_sel  (addr_sel[g]),
            .if_stall  (if_stall[g]),
            .dm_stall  (dm_stall[g])
        );
    end

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s idx=%0d got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic clr_inputs();
        for (int k = 0; k < NI; k++) begin
            if_req[k] = 1'b0; if_addr[k] = '0;
            dm_req[k] = 1'b0; dm_we[k] = 1'b0; dm_addr[k] = '0; dm_wdata[k] = '0;
        end
    endtask

    task automatic chk_rst(input string nm, input int k);
        chk({nm, ".mem_en"},   k, 32'(mem_en[k]), 32'd0);
        chk({nm, ".mem_we"},   k, 32'(mem_we[k]), 32'd0);
        chk({nm, ".if_ack"},   k, 32'(if_ack[k]), 32'd0);
        chk({nm, ".dm_ack"},   k, 32'(dm_ack[k]), 32'd0);
        chk({nm, ".addr_sel"}, k, 32'(addr_sel[k]), 32'd3);
        chk({nm, ".mem_addr"}, k, mem_addr[k], 32'd0);
    endtask

    // Directed vectors for the MEM_LAT=2 instance
    typedef struct packed {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        e_en;
        logic        e_we;
        logic [1:0]  e_sel;
        logic [31:0] e_addr;
        logic        e_ia;
        logic        e_da;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl [NV];

    task automatic setv(input int i, input logic ir, input logic [31:0] ia, input logic dr,
                        input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                        input logic en, input logic we, input logic [1:0] sel,
                        input logic [31:0] ad, input logic iack, input logic dack,
                        input logic [31:0] rd);
        tbl[i] = '{ir, ia, dr, dw, da, dwd, en, we, sel, ad, iack, dack, rd};
    endtask

    // Transaction-level reference model state for the random phase
    bit          m_act  [NI];
    bit          m_own  [NI];   // 1 = data requester
    bit          m_we   [NI];
    logic [31:0] m_addr [NI];
    int          m_resp [NI];   // cycle in which the ack is due
    int          m_mown [NI];   // requester masked, -1 none
    int          m_mcyc [NI];   // cycle in which the mask applies
    bit          p_ia   [NI];
    bit          p_da   [NI];

    initial begin
        rst = 1'b1;
        clr_inputs();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < NI; k++) chk_rst("reset", k);
        rst = 1'b0;

        // Table: single fetch, store then deferred fetch (MEM_LAT=2)
        setv(0,  0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 2'd3, 32'h0,   0, 0, 32'h0);
        setv(1,  1, 32'h40, 0, 0, 32'h0,   32'h0,        1, 0, 2'd0, 32'h40,  0, 0, 32'h0);
        setv(2,  1, 32'h40, 0, 0, 32'h0,   32'h0,        0, 0, 2'd2, 32'h40,  0, 0, 32'h0);
        setv(3,  1, 32'h40, 0, 0, 32'h0,   32'h0,        0, 0, 2'd2, 32'h40,  1, 0, 32'h00A00093);
        setv(4,  0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 2'd3, 32'h0,   0, 0, 32'h0);
        setv(5,  1, 32'h80, 1, 1, 32'h100, 32'hDEADBEEF, 1, 1, 2'd1, 32'h100, 0, 0, 32'h0);
        setv(6,  1, 32'h80, 1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 2'd2, 32'h100, 0, 1, 32'h0);
        setv(7,  1, 32'h80, 0, 0, 32'h0,   32'h0,        1, 0, 2'd0, 32'h80,  0, 0, 32'h0);
        setv(8,  1, 32'h80, 0, 0, 32'h0,   32'h0,        0, 0, 2'd2, 32'h80,  0, 0, 32'h0);
        setv(9,  1, 32'h80, 0, 0, 32'h0,   32'h0,        0, 0, 2'd2, 32'h80,  1, 0, 32'h0080FF7F);
        setv(10, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 2'd3, 32'h0,   0, 0, 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            if_req[1] = tbl[i].if_req;  if_addr[1]  = tbl[i].if_addr;
            dm_req[1] = tbl[i].dm_req;  dm_we[1]    = tbl[i].dm_we;
            dm_addr[1] = tbl[i].dm_addr; dm_wdata[1] = tbl[i].dm_wdata;
            #1;
            chk("tbl.mem_en",   i, 32'(mem_en[1]),   32'(tbl[i].e_en));
            chk("tbl.mem_we",   i, 32'(mem_we[1]),   32'(tbl[i].e_we));
            chk("tbl.addr_sel", i, 32'(addr_sel[1]), 32'(tbl[i].e_sel));
            chk("tbl.mem_addr", i, mem_addr[1],      tbl[i].e_addr);
            chk("tbl.if_ack",   i, 32'(if_ack[1]),   32'(tbl[i].e_ia));
            chk("tbl.dm_ack",   i, 32'(dm_ack[1]),   32'(tbl[i].e_da));
            chk("tbl.if_stall", i, 32'(if_stall[1]), 32'(tbl[i].if_req & ~tbl[i].e_ia));
            chk("tbl.dm_stall", i, 32'(dm_stall[1]), 32'(tbl[i].dm_req & ~tbl[i].e_da));
            if (tbl[i].e_ia) chk("tbl.if_rdata", i, if_rdata[1], tbl[i].e_rdata);
            if (tbl[i].e_we) chk("tbl.mem_wdata", i, mem_wdata[1], tbl[i].dm_wdata);
        end
        clr_inputs();

        // Reset during a store grant cycle (MEM_LAT=3): mem_we drops at once
        @(negedge clk);
        dm_req[2] = 1'b1; dm_we[2] = 1'b1; dm_addr[2] = 32'h300; dm_wdata[2] = 32'h12345678;
        #1 chk("rst_st.we_before", 2, 32'(mem_we[2]), 32'd1);
        #1 rst = 1'b1;
        #1 chk_rst("rst_st", 2);
        @(negedge clk);
        dm_req[2] = 1'b0; dm_we[2] = 1'b0;
        rst = 1'b0;

        // Reset during BUSY (MEM_LAT=3), held fetch is re-granted afterwards
        @(negedge clk);
        if_req[2] = 1'b1; if_addr[2] = 32'h200;
        #1 chk("rst_bz.grant_sel", 2, 32'(addr_sel[2]), 32'd0);
        @(negedge clk);
        #1 chk("rst_bz.busy_sel", 2, 32'(addr_sel[2]), 32'd2);
        #1 rst = 1'b1;
        #1 chk_rst("rst_bz", 2);
        @(negedge clk);
        #1 chk("rst_bz.no_ack", 2, 32'(if_ack[2]), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_bz.regrant_en",   2, 32'(mem_en[2]),   32'd1);
        chk("rst_bz.regrant_sel",  2, 32'(addr_sel[2]), 32'd0);
        chk("rst_bz.regrant_addr", 2, mem_addr[2],      32'h200);
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            #1 chk("rst_bz.ack", j, 32'(if_ack[2]), 32'(j == 3));
            if (j == 3) chk("rst_bz.rdata", j, if_rdata[2], 32'h0200FDFF);
        end
        @(negedge clk);
        clr_inputs();
        @(negedge clk);

        // Both requesters continuously pending (MEM_LAT=1): strict alternation
        @(negedge clk);
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h20;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("alt.dm_ack",   i, 32'(dm_ack[0]),   32'(i % 4 == 1));
            chk("alt.if_ack",   i, 32'(if_ack[0]),   32'(i % 4 == 3));
            chk("alt.mem_en",   i, 32'(mem_en[0]),   32'(i % 2 == 0));
            chk("alt.addr_sel", i, 32'(addr_sel[0]),
                (i % 2 == 1) ? 32'd2 : ((i % 4 == 0) ? 32'd1 : 32'd0));
            chk("alt.dm_stall", i, 32'(dm_stall[0]), 32'(i % 4 != 1));
            chk("alt.if_stall", i, 32'(if_stall[0]), 32'(i % 4 != 3));
            if (i % 4 == 1) chk("alt.dm_rdata", i, dm_rdata[0], mem_f(32'h20));
            if (i % 4 == 3) chk("alt.if_rdata", i, if_rdata[0], mem_f(32'h10));
        end
        @(negedge clk);
        clr_inputs();

        // Fresh start for the random phase
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            m_act[k] = 1'b0; m_own[k] = 1'b0; m_we[k] = 1'b0; m_addr[k] = '0;
            m_resp[k] = -1; m_mown[k] = -1; m_mcyc[k] = -1; p_ia[k] = 1'b0; p_da[k] = 1'b0;
        end

        for (int cyc = 0; cyc < NRAND; cyc++) begin
            @(negedge clk);
            // Requesters: hold until ack, occasionally abandon, sometimes re-request at once
            for (int k = 0; k < NI; k++) begin
                if (!if_req[k] || p_ia[k]) begin
                    if_req[k]  = 1'($urandom_range(1, 0));
                    if_addr[k] = 32'($urandom_range(1023, 0)) << 2;
                end else if ($urandom_range(31, 0) == 0) begin
                    if_req[k] = 1'b0;
                end
                if (!dm_req[k] || p_da[k]) begin
                    dm_req[k]   = 1'($urandom_range(1, 0));
                    dm_we[k]    = 1'($urandom_range(1, 0));
                    dm_addr[k]  = 32'($urandom_range(1023, 0)) << 2;
                    dm_wdata[k] = $urandom;
                end else if ($urandom_range(31, 0) == 0) begin
                    dm_req[k] = 1'b0;
                end
            end
            #1;
            for (int k = 0; k < NI; k++) begin
                logic        e_en, e_we, e_ia, e_da, dm_ok, if_ok;
                logic [1:0]  e_sel;
                logic [31:0] e_addr;
                e_en = 1'b0; e_we = 1'b0; e_ia = 1'b0; e_da = 1'b0;
                e_sel = 2'd3; e_addr = '0;
                dm_ok = dm_req[k] && !(m_mcyc[k] == cyc && m_mown[k] == 1);
                if_ok = if_req[k] && !(m_mcyc[k] == cyc && m_mown[k] == 0);
                if (m_act[k]) begin
                    e_sel  = 2'd2;
                    e_addr = m_addr[k];
                    if (cyc == m_resp[k]) begin
                        e_ia = !m_own[k];
                        e_da = m_own[k];
                    end
                end else if (dm_ok) begin
                    e_en = 1'b1; e_we = dm_we[k]; e_sel = 2'd1; e_addr = dm_addr[k];
                end else if (if_ok) begin
                    e_en = 1'b1; e_sel = 2'd0; e_addr = if_addr[k];
                end

                chk("rnd.mem_en",   k, 32'(mem_en[k]),   32'(e_en));
                chk("rnd.mem_we",   k, 32'(mem_we[k]),   32'(e_we));
                chk("rnd.addr_sel", k, 32'(addr_sel[k]), 32'(e_sel));
                chk("rnd.mem_addr", k, mem_addr[k],      e_addr);
                chk("rnd.if_ack",   k, 32'(if_ack[k]),   32'(e_ia));
                chk("rnd.dm_ack",   k, 32'(dm_ack[k]),   32'(e_da));
                chk("rnd.if_stall", k, 32'(if_stall[k]), 32'(if_req[k] & ~e_ia));
                chk("rnd.dm_stall", k, 32'(dm_stall[k]), 32'(dm_req[k] & ~e_da));
                if (e_ia) chk("rnd.if_rdata", k, if_rdata[k], mem_f(m_addr[k]));
                if (e_da && !m_we[k]) chk("rnd.dm_rdata", k, dm_rdata[k], mem_f(m_addr[k]));
                if (e_we) chk("rnd.mem_wdata", k, mem_wdata[k], dm_wdata[k]);

                // Advance the transaction model
                if (e_ia || e_da) begin
                    m_act[k]  = 1'b0;
                    m_mown[k] = m_own[k] ? 1 : 0;
                    m_mcyc[k] = cyc + 1;
                end else if (e_en) begin
                    m_act[k]  = 1'b1;
                    m_own[k]  = (e_sel == 2'd1);
                    m_we[k]   = e_we;
                    m_addr[k] = e_addr;
                    m_resp[k] = cyc + (e_we ? 1 : (k + 1));
                end
                p_ia[k] = e_ia;
                p_da[k] = e_da;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates a single-ported unified instruction/data memory between the IF-stage fetch requester and the MEM-stage load/store requester in the RISC-V pipeline. It sequences each access through grant, latency wait and response, and holds the memory address stable for the whole access. It drives the address-select code of a 4:1 address mux and produces per-requester acks and stall signals for the hazard logic.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, memory data width
MEM_LAT, 1, memory read latency in cycles (legal 1..3)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
if_req  in  1  fetch request, level, held until if_ack
if_addr  in  ADDR_W  fetch address (PC)
if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  out  DATA_W  fetched instruction
dm_req  in  1  data request, level, held until dm_ack
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_ack  out  1  one-cycle pulse: data access complete
dm_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
addr_sel  out  2  address-mux select: 00 if_addr, 01 dm_addr, 10 held address, 11 zero
if_stall  out  1  if_req & ~if_ack
dm_stall  out  1  dm_req & ~dm_ack (stalls the whole pipe)

Behaviour:
- FSM states: IDLE, BUSY, RESP. Owner register: IF or DM. 2-bit latency counter. Address and write-data hold registers.
- Reset (async): state IDLE, counter 0, owner IF, mask 0. Outputs: mem_en 0, mem_we 0, if_ack 0, dm_ack 0, addr_sel 11, mem_addr 0. rdata outputs are don't-care.
- IDLE: unmasked requests are eligible.
  - DM has priority over IF.
  - Grant cycle T: mem_en 1, addr_sel 00 or 01 per owner. mem_we = dm_we if the owner is DM. The address (and wdata) is captured into the hold registers.
- Load or fetch: move to BUSY with counter = MEM_LAT-1.
  - From cycle T+1, addr_sel is 10 and mem_en is 0.
  - BUSY decrements the counter. When the counter is 0 and the state is BUSY, move to RESP.
  - When MEM_LAT=1, go directly from T to RESP.
- Store: always move to RESP at T+1 (write completes in the grant cycle). mem_we is high only in T.
- RESP (cycle T+MEM_LAT for reads, T+1 for writes):
  - The owner's ack is 1. Its rdata = mem_rdata pass-through.
  - The other ack is 0.
  - The next state is IDLE.
- Mask: in the IDLE cycle directly after a RESP, the requester just acked is ineligible. This absorbs the requester's registered req deassertion. It also guarantees alternation when both requesters are continuously pending, so neither starves.
- No new grant is issued in BUSY or RESP. A request arriving then waits.
- A req dropped mid-access does not abort it: the access completes and ack still pulses.
- Throughput: one access per MEM_LAT+1 cycles (reads), 2 cycles (writes).
- Reset mid-BUSY or mid-RESP: immediate return to the reset state. No ack is issued. mem_we drops asynchronously.
- mem_wdata = hold register during BUSY, dm_wdata in the grant cycle.

Decomposition:
- Shared package: state encoding (IDLE, BUSY, RESP), owner encoding, and the addr_sel constants (SEL_IF=00, SEL_DM=01, SEL_HOLD=10, SEL_ZERO=11).
- Sub-module: one mux4to1 instance (n=ADDR_W) forms mem_addr. Inputs are a=if_addr, b=dm_addr, c=held address, d=0, with sel=addr_sel.

Test Plan:
- Reset: assert rst mid-simulation -> within the same cycle mem_en=0, mem_we=0, if_ack=dm_ack=0, addr_sel=11.
- Single fetch, MEM_LAT=2, if_addr=0x40, memory returns 0x00A00093 -> grant at T with addr_sel=00, mem_addr=0x40 held through T+1 with addr_sel=10. At T+2, if_ack=1 and if_rdata=0x00A00093.
- IF and DM load both raised at cycle T, MEM_LAT=1 -> dm_ack at T+1, IDLE at T+2 grants IF (DM masked), if_ack at T+3. dm_stall=1 during T..T+0 and 0 at T+1.
- Store dm_addr=0x100, dm_wdata=0xDEADBEEF -> mem_we=1 only in T, dm_ack=1 at T+1. IF pending is not granted before T+2.
- Both requesters held high for 10 cycles, MEM_LAT=1 -> grants alternate DM, IF, DM, IF. No ack is ever simultaneous.
- rst pulsed during BUSY (MEM_LAT=3) -> no ack, state IDLE. After release, the held if_req is re-granted and acked MEM_LAT cycles after the new grant.
